// File: rtl/rv_wb_arb.sv
// -----------------------------------------------------------------------------
// rv_wb_arb -- write-back arbiter for the single register-file write port.
//
// Execution units (default: 0=ALU, 1=LSU, 2=MDU) raise write requests over a
// valid/ready handshake. At most one request is granted per cycle using a
// round-robin pointer. The granted write is captured into a registered output
// stage that drives the register-file write port one cycle later.
//
// Optional build macro:
//   RV_WB_BYPASS_EN - adds a same-cycle bypass of the write landing this cycle
//                     for the two decode read ports.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   PW    round-robin pointer / grant id width, 2**PW >= NREQ
//
// Ports:
//   clk, rstn            core clock, asynchronous active-low reset
//   req_valid_i[NREQ]    per-requester write request valid
//   req_rd_i             destination index, requester i at [5i +: 5]
//   req_data_i           write data, requester i at [MXLEN*i +: MXLEN]
//   req_ready_o[NREQ]    one-hot grant (combinational)
//   wr_reg_o/wr_data_o   register-file write index / data (registered)
//   wr_en_o              register-file write enable (registered, never for x0)
//   grant_id_o           index of the last granted requester (registered)
//   busy_o               any request valid this cycle (combinational)
//   rd_reg1_i/rd_reg2_i  (bypass) decode read indices
//   byp1_hit_o/byp2_hit_o(bypass) read index matches the write landing now
//   byp_data_o           (bypass) data of the write landing now
// -----------------------------------------------------------------------------

`ifndef MXLEN
`define MXLEN 32
`endif

module rv_wb_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*5-1:0]        req_rd_i,
    input  logic [NREQ*`MXLEN-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    output logic [4:0]               wr_reg_o,
    output logic [`MXLEN-1:0]        wr_data_o,
    output logic                     wr_en_o,
    output logic [PW-1:0]            grant_id_o,
`ifdef RV_WB_BYPASS_EN
    input  logic [4:0]               rd_reg1_i,
    input  logic [4:0]               rd_reg2_i,
    output logic                     byp1_hit_o,
    output logic                     byp2_hit_o,
    output logic [`MXLEN-1:0]        byp_data_o,
`endif
    output logic                     busy_o
);

    localparam int unsigned XLEN = `MXLEN;
    localparam int unsigned RW   = 5;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] grant_c;
    logic [PW-1:0]   gnt_idx_c;
    logic            gnt_any_c;
    logic [RW-1:0]   gnt_rd_c;
    logic [XLEN-1:0] gnt_data_c;
    logic [PW-1:0]   ptr_nxt_c;

    // Round-robin scan: offset k from ptr, wrapped by explicit subtraction so
    // a non-power-of-two NREQ never selects a missing requester.
    always_comb begin
        int unsigned pos;
        grant_c   = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        pos       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!gnt_any_c && (pos == i) && req_valid_i[i]) begin
                    grant_c[i] = 1'b1;
                    gnt_idx_c  = PW'(i);
                    gnt_any_c  = 1'b1;
                end
            end
        end
    end

    // One-hot mux of the granted requester's payload.
    always_comb begin
        gnt_rd_c   = '0;
        gnt_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_c[i]) begin
                gnt_rd_c   = gnt_rd_c   | req_rd_i[i*RW +: RW];
                gnt_data_c = gnt_data_c | req_data_i[i*XLEN +: XLEN];
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NREQ-1.
    always_comb begin
        ptr_nxt_c = gnt_idx_c + PW'(1);
        if (gnt_idx_c == PW'(NREQ - 1)) begin
            ptr_nxt_c = '0;
        end
    end

    // Ready is the grant itself; suppressed while reset is asserted.
    assign req_ready_o = rstn ? grant_c : '0;
    assign busy_o      = |req_valid_i;

    // Handshake happens exactly when a grant exists (ready mirrors grant).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            wr_en_o    <= 1'b0;
            wr_reg_o   <= '0;
            wr_data_o  <= '0;
            grant_id_o <= '0;
        end else if (gnt_any_c) begin
            ptr        <= ptr_nxt_c;
            wr_en_o    <= (gnt_rd_c != '0);
            wr_reg_o   <= gnt_rd_c;
            wr_data_o  <= gnt_data_c;
            grant_id_o <= gnt_idx_c;
        end else begin
            wr_en_o    <= 1'b0;
        end
    end

`ifdef RV_WB_BYPASS_EN
    // The register file only shows this write after the edge; forward it now.
    assign byp1_hit_o = wr_en_o && (wr_reg_o == rd_reg1_i) && (rd_reg1_i != '0);
    assign byp2_hit_o = wr_en_o && (wr_reg_o == rd_reg2_i) && (rd_reg2_i != '0);
    assign byp_data_o = wr_data_o;
`endif

endmodule

// File: tb/tb_rv_wb_arb.sv
// -----------------------------------------------------------------------------
// tb_rv_wb_arb -- self-checking bench for rv_wb_arb (NREQ=3, PW=2).
// Vector table, directed multi-cycle sequences, then constrained-random
// requesters checked against a round-robin reference model.
// -----------------------------------------------------------------------------

`ifndef MXLEN
`define MXLEN 32
`endif

module tb_rv_wb_arb;

    localparam int unsigned NREQ = 3;
    localparam int unsigned PW   = 2;
    localparam int unsigned XLEN = `MXLEN;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*5-1:0]      req_rd;
    logic [NREQ*XLEN-1:0]   req_data;
    logic [NREQ-1:0]        req_ready;
    logic [4:0]             wr_reg;
    logic [XLEN-1:0]        wr_data;
    logic                   wr_en;
    logic [PW-1:0]          grant_id;
    logic                   busy;
`ifdef RV_WB_BYPASS_EN
    logic [4:0]             rd_reg1 = 5'd0;
    logic [4:0]             rd_reg2 = 5'd0;
    logic                   byp1_hit;
    logic                   byp2_hit;
    logic [XLEN-1:0]        byp_data;
`endif

    rv_wb_arb #(.NREQ(NREQ), .PW(PW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid),
        .req_rd_i    (req_rd),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .wr_reg_o    (wr_reg),
        .wr_data_o   (wr_data),
        .wr_en_o     (wr_en),
        .grant_id_o  (grant_id),
`ifdef RV_WB_BYPASS_EN
        .rd_reg1_i   (rd_reg1),
        .rd_reg2_i   (rd_reg2),
        .byp1_hit_o  (byp1_hit),
        .byp2_hit_o  (byp2_hit),
        .byp_data_o  (byp_data),
`endif
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                         input logic [XLEN-1:0] d2);
        req_valid = v;
        req_rd    = {r2, r1, r0};
        req_data  = {d2, d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive('0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0] valid;
        logic [4:0]      rd0, rd1, rd2;
        logic [XLEN-1:0] d0, d1, d2;
        logic [NREQ-1:0] exp_ready;
        logic            exp_en;
        logic [4:0]      exp_reg;
        logic [XLEN-1:0] exp_data;
        logic [PW-1:0]   exp_gid;
    } vec_t;

    vec_t tbl[12];

    // Random-phase model state
    logic [NREQ-1:0] pend;
    logic [4:0]      m_rd[NREQ];
    logic [XLEN-1:0] m_data[NREQ];
    int              waits[NREQ];
    int              m_ptr;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    logic            e_en;
    logic [4:0]      e_reg;
    logic [XLEN-1:0] e_data;
    logic [PW-1:0]   e_gid;

    initial begin
        // Rows run back-to-back from reset (pointer starts at 0).
        tbl[0]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                    3'b000, 1'b0, 5'd0, 32'h0, 2'd0};
        tbl[1]  = '{3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,
                    3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1};
        tbl[2]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                    3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1};
        tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                    3'b100, 1'b1, 5'd3, 32'h33, 2'd2};
        tbl[4]  = '{3'b011, 5'd1, 5'd2, 5'd0, 32'h11, 32'h22, 32'h0,
                    3'b001, 1'b1, 5'd1, 32'h11, 2'd0};
        tbl[5]  = '{3'b010, 5'd0, 5'd2, 5'd0, 32'h0, 32'h22, 32'h0,
                    3'b010, 1'b1, 5'd2, 32'h22, 2'd1};
        tbl[6]  = '{3'b001, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0,
                    3'b001, 1'b0, 5'd0, 32'h1234, 2'd0};
        tbl[7]  = '{3'b011, 5'd4, 5'd6, 5'd0, 32'h44, 32'h66, 32'h0,
                    3'b010, 1'b1, 5'd6, 32'h66, 2'd1};
        tbl[8]  = '{3'b001, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0, 32'h0,
                    3'b001, 1'b1, 5'd4, 32'h44, 2'd0};
        tbl[9]  = '{3'b110, 5'd0, 5'd7, 5'd8, 32'h0, 32'h77, 32'h88,
                    3'b010, 1'b1, 5'd7, 32'h77, 2'd1};
        tbl[10] = '{3'b100, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h88,
                    3'b100, 1'b1, 5'd8, 32'h88, 2'd2};
        tbl[11] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                    3'b000, 1'b0, 5'd8, 32'h88, 2'd2};

        // ---- reset release, idle ----
        do_reset();
        for (int c = 0; c < 10; c++) begin
            chk("idle_wr_en", 64'(wr_en), 64'(0));
            chk("idle_ready", 64'(req_ready), 64'(0));
            chk("idle_gid", 64'(grant_id), 64'(0));
            tick();
        end

        // ---- vector table ----
        do_reset();
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].valid, tbl[r].rd0, tbl[r].rd1, tbl[r].rd2,
                  tbl[r].d0, tbl[r].d1, tbl[r].d2);
            #1;
            chk($sformatf("tbl%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            chk($sformatf("tbl%0d_busy", r), 64'(busy), 64'(|tbl[r].valid));
            tick();
            chk($sformatf("tbl%0d_wr_en", r), 64'(wr_en), 64'(tbl[r].exp_en));
            chk($sformatf("tbl%0d_wr_reg", r), 64'(wr_reg), 64'(tbl[r].exp_reg));
            chk($sformatf("tbl%0d_wr_data", r), 64'(wr_data), 64'(tbl[r].exp_data));
            chk($sformatf("tbl%0d_gid", r), 64'(grant_id), 64'(tbl[r].exp_gid));
        end

        // ---- all three held valid: 0,1,2,0,1,2 ----
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 5'd1, 5'd2, 5'd3, XLEN'(100 + c), XLEN'(200 + c), XLEN'(300 + c));
            #1;
            chk($sformatf("all3_ready%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
            tick();
            chk($sformatf("all3_gid%0d", c), 64'(grant_id), 64'(c % 3));
            chk($sformatf("all3_wr_en%0d", c), 64'(wr_en), 64'(1));
            chk($sformatf("all3_reg%0d", c), 64'(wr_reg), 64'((c % 3) + 1));
            chk($sformatf("all3_data%0d", c), 64'(wr_data), 64'(100 * ((c % 3) + 1) + c));
        end

        // ---- x0 write: accepted, no enable, pointer still advances ----
        do_reset();
        drive(3'b011, 5'd0, 5'd9, 5'd0, 32'h1234, 32'h99, 32'h0);
        #1;
        chk("x0_ready", 64'(req_ready), 64'(3'b001));
        tick();
        chk("x0_wr_en", 64'(wr_en), 64'(0));
        chk("x0_gid", 64'(grant_id), 64'(0));
        drive(3'b010, 5'd0, 5'd9, 5'd0, 32'h0, 32'h99, 32'h0);
        #1;
        chk("x0_next_ready", 64'(req_ready), 64'(3'b010));
        tick();
        chk("x0_next_wr_en", 64'(wr_en), 64'(1));
        chk("x0_next_reg", 64'(wr_reg), 64'(9));
        chk("x0_next_data", 64'(wr_data), 64'(32'h99));

        // ---- asynchronous reset while a write is landing ----
        do_reset();
        drive(3'b001, 5'd3, 5'd0, 5'd0, 32'hABCD, 32'h0, 32'h0);
        tick();
        drive(3'b101, 5'd3, 5'd0, 5'd4, 32'hABCD, 32'h0, 32'h4444);
        chk("arst_pre_wr_en", 64'(wr_en), 64'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_wr_en", 64'(wr_en), 64'(0));
        chk("arst_ready", 64'(req_ready), 64'(0));
        chk("arst_reg", 64'(wr_reg), 64'(0));
        #2;
        rstn = 1'b1;
        #1;
        chk("arst_first_ready", 64'(req_ready), 64'(3'b001));
        tick();
        chk("arst_first_gid", 64'(grant_id), 64'(0));
        chk("arst_first_reg", 64'(wr_reg), 64'(3));

`ifdef RV_WB_BYPASS_EN
        // ---- bypass of the write landing this cycle ----
        do_reset();
        drive(3'b001, 5'd7, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
        tick();
        drive('0, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        rd_reg1 = 5'd7;
        rd_reg2 = 5'd0;
        #1;
        chk("byp1_hit", 64'(byp1_hit), 64'(1));
        chk("byp2_hit", 64'(byp2_hit), 64'(0));
        chk("byp_data", 64'(byp_data), 64'(32'h55));
        rd_reg2 = 5'd7;
        rd_reg1 = 5'd6;
        #1;
        chk("byp1_miss", 64'(byp1_hit), 64'(0));
        chk("byp2_hit7", 64'(byp2_hit), 64'(1));
        tick();
        chk("byp2_no_wr", 64'(byp2_hit), 64'(0));
        rd_reg1 = 5'd0;
        rd_reg2 = 5'd0;
`endif

        // ---- random requesters vs. round-robin model ----
        do_reset();
        m_ptr  = 0;
        pend   = '0;
        e_en   = 1'b0;
        e_reg  = '0;
        e_data = '0;
        e_gid  = '0;
        for (int i = 0; i < NREQ; i++) begin
            waits[i]  = 0;
            m_rd[i]   = '0;
            m_data[i] = '0;
        end
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 99) < 45)) begin
                    pend[i]   = 1'b1;
                    m_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
                    m_data[i] = XLEN'($urandom);
                end
            end
            drive(pend, m_rd[0], m_rd[1], m_rd[2], m_data[0], m_data[1], m_data[2]);
            #1;
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (g < 0 && pend[j]) g = j;
            end
            exp_rdy = (g >= 0) ? NREQ'(1 << g) : '0;
            chk("rand_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rand_busy", 64'(busy), 64'(|pend));
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    if (req_ready[i]) begin
                        n_chk++;
                        if (waits[i] > NREQ - 1) begin
                            n_fail++;
                            $display("FAIL rand_starve: req%0d waited %0d grants, limit %0d",
                                     i, waits[i], NREQ - 1);
                        end
                        waits[i] = 0;
                    end else if (|req_ready) begin
                        waits[i]++;
                    end
                end
            end
            tick();
            if (g >= 0) begin
                e_en     = (m_rd[g] != 5'd0);
                e_reg    = m_rd[g];
                e_data   = m_data[g];
                e_gid    = PW'(g);
                m_ptr    = (g + 1) % NREQ;
                pend[g]  = 1'b0;
            end else begin
                e_en = 1'b0;
            end
            chk("rand_wr_en", 64'(wr_en), 64'(e_en));
            chk("rand_wr_reg", 64'(wr_reg), 64'(e_reg));
            chk("rand_wr_data", 64'(wr_data), 64'(e_data));
            chk("rand_gid", 64'(grant_id), 64'(e_gid));
            if (wr_en && wr_reg == 5'd0) begin
                n_fail++;
                $display("FAIL rand_x0_write: wr_en with index 0, required no enable");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_wb_arb.md
Name: rv_wb_arb

Overview:
- Write-back arbiter for the single register-file write port.
- Up to NREQ execution units (default: ALU, LSU, MDU as requesters 0/1/2) present write requests over valid/ready handshakes.
- Grants at most one request per cycle using round-robin priority.
- Drives the register-file write signals (wr_reg/wr_data/wr_en) from a registered output stage.

Parameters:
- NREQ, 3, number of write-back requesters (2..8).
- PW, 2, round-robin pointer width; must satisfy 2^PW >= NREQ.

Ports:
- clk  input  1  core clock
- rstn  input  1  asynchronous active-low reset
- req_valid_i  input  NREQ  per-requester write request valid
- req_rd_i  input  NREQ*5  destination register index, requester i at [5i+4:5i]
- req_data_i  input  NREQ*`MXLEN  write data, requester i at [`MXLEN*i +: `MXLEN]
- req_ready_o  output  NREQ  one-hot grant; handshake completes when valid&ready
- wr_reg_o  output  5  register-file write index
- wr_data_o  output  `MXLEN  register-file write data
- wr_en_o  output  1  register-file write enable
- grant_id_o  output  PW  index of the last granted requester, for debug/perf
- busy_o  output  1  any req_valid_i asserted this cycle

Behaviour:
- Reset (rstn=0, asynchronous):
  - wr_en_o=0, wr_reg_o=0, wr_data_o=0, grant_id_o=0.
  - Round-robin pointer ptr=0.
  - req_ready_o=0 while in reset.
- Arbitration (combinational, same cycle):
  - Scan requesters starting at ptr, ascending, wrapping modulo NREQ.
  - The first requester with valid=1 gets req_ready_o[i]=1; all other ready bits are 0.
  - No valid request means req_ready_o=0.
  - req_ready_o never depends on the granted requester's own ready.
- Handshake rules:
  - Once req_valid_i[i] is raised, requester i holds valid, rd and data stable until it sees ready=1 at a clock edge.
  - Valid may drop only after the handshake completes.
- Pointer update:
  - On a handshake with requester g, ptr <= (g+1) mod NREQ. Handle the wrap explicitly; NREQ need not be a power of 2.
  - With no handshake, ptr holds.
- Output stage:
  - On the clock edge of a handshake with g: wr_reg_o <= req_rd_i[g], wr_data_o <= req_data_i[g], grant_id_o <= g.
  - In the same edge, wr_en_o <= (req_rd_i[g] != 0).
  - With no handshake: wr_en_o <= 0, wr_reg_o/wr_data_o hold, grant_id_o holds.
  - Latency: request accepted in cycle N; wr_en_o high in cycle N+1; register file updated at the end of cycle N+1.
- x0 writes: accepted, the handshake completes and ptr advances, but wr_en_o stays 0. The register file must never see wr_en with index 0.
- Throughput: one write per cycle sustained. A starved requester waits at most NREQ-1 grants.
- Simultaneous events:
  - All NREQ valid at once: granted in order ptr, ptr+1, … on consecutive cycles.
  - A new valid arriving while another requester is granted joins the scan next cycle.
- Reset mid-operation:
  - Any in-flight wr_en_o is dropped immediately (asynchronous) and ptr returns to 0.
  - Requesters must treat an un-handshaked request as discarded.
- Same rd from two requesters in consecutive grants: both writes are issued in grant order; the last one wins in the register file.

Optional Feature:
- Macro: RV_WB_BYPASS_EN.
- When defined, add these ports:
  - rd_reg1_i/rd_reg2_i input 5
  - byp1_hit_o/byp2_hit_o output 1
  - byp_data_o output `MXLEN
- byp{n}_hit_o = wr_en_o & (wr_reg_o == rd_reg{n}_i) & (rd_reg{n}_i != 0). Combinational, no added latency.
- byp_data_o = wr_data_o.
- Purpose: decode muxes in the write value landing this cycle, which the register file's combinational read does not yet show.
- When undefined: the ports are absent, no extra logic, and behaviour is otherwise identical.

Test Plan:
- Reset release, no requests:
  - wr_en_o=0, req_ready_o=000, grant_id_o=0 for 10 cycles.
- Single request, requester 1 (LSU) valid, rd=5, data=0xDEADBEEF:
  - ready_o=010 in the same cycle.
  - Next cycle wr_en_o=1, wr_reg_o=5, wr_data_o=0xDEADBEEF.
  - Following cycle wr_en_o=0.
- All three valid and held continuously from ptr=0:
  - Grants 0,1,2,0,1,2 on consecutive cycles; wr_en_o high every cycle after the first.
- Requester 0 with rd=0, data=0x1234:
  - Handshake completes and ptr becomes 1, but wr_en_o stays 0.
  - A concurrent requester 1 is granted next cycle.
- Assert rstn=0 mid-cycle while wr_en_o=1:
  - wr_en_o falls immediately without a clock edge.
  - After release the first grant goes to the lowest-index valid requester.
- With RV_WB_BYPASS_EN defined, grant rd=7, data=0x55 and drive rd_reg1_i=7, rd_reg2_i=0 the next cycle:
  - byp1_hit_o=1, byp2_hit_o=0, byp_data_o=0x55.
